// File: rtl/e1_tx_line_enc.sv
// E1 transmit line encoder: NL independent HDB3/AMI encoders with AIS forcing,
// each driving a hi/lo pulse pair of programmable width.
module e1_tx_line_enc #(
    parameter int NL   = 1,
    parameter int PW_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NL-1:0]   in_bit,
    input  logic [NL-1:0]   in_valid,
    input  logic [NL-1:0]   ctrl_hdb3,
    input  logic [NL-1:0]   ctrl_ais,
    input  logic [NL-1:0]   ctrl_invert,
    input  logic [PW_W-1:0] ctrl_pw,
    output logic [NL-1:0]   out_hi,
    output logic [NL-1:0]   out_lo,
    output logic [NL-1:0]   out_stb,
    output logic [NL-1:0]   stat_sub
);

    localparam logic [1:0] SYM_SPACE = 2'd0;
    localparam logic [1:0] SYM_MARK  = 2'd1;
    localparam logic [1:0] SYM_B     = 2'd2;
    localparam logic [1:0] SYM_V     = 2'd3;

    for (genvar g = 0; g < NL; g++) begin : g_line
        logic [1:0]      r_stg0, r_stg1, r_stg2, r_stg3;
        logic [2:0]      r_zcnt;
        logic            r_last_pol;   // 1 = positive
        logic            r_v_odd;
        logic [PW_W-1:0] r_hi_cnt, r_lo_cnt;
        logic            r_stb, r_sub;

        logic       w_d;
        logic [2:0] w_zcnt_inc, w_zcnt_next;
        logic       w_sub;
        logic       w_pos, w_neg;
        logic       w_last_pol_next, w_v_odd_next;
        logic       w_hi_act, w_lo_act;

        always_comb begin
            w_d             = ctrl_ais[g] | in_bit[g];
            w_zcnt_inc      = (r_zcnt == 3'd4) ? 3'd4 : r_zcnt + 3'd1;
            w_zcnt_next     = (!ctrl_hdb3[g] || w_d) ? 3'd0 : w_zcnt_inc;
            w_sub           = ctrl_hdb3[g] && (w_zcnt_next == 3'd4);
            w_pos           = 1'b0;
            w_neg           = 1'b0;
            w_last_pol_next = r_last_pol;
            w_v_odd_next    = r_v_odd;
            case (r_stg3)
                SYM_MARK, SYM_B: begin
                    w_pos           = ~r_last_pol;
                    w_neg           = r_last_pol;
                    w_last_pol_next = ~r_last_pol;
                    w_v_odd_next    = ~r_v_odd;
                end
                SYM_V: begin
                    w_pos        = r_last_pol;
                    w_neg        = ~r_last_pol;
                    w_v_odd_next = 1'b0;
                end
                default: ;
            endcase
        end

        // The substitution choice uses parity after the symbol popped this strobe,
        // so a V leaving the pipeline is already counted.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_stg0     <= SYM_SPACE;
                r_stg1     <= SYM_SPACE;
                r_stg2     <= SYM_SPACE;
                r_stg3     <= SYM_SPACE;
                r_zcnt     <= 3'd0;
                r_last_pol <= 1'b0;
                r_v_odd    <= 1'b0;
                r_hi_cnt   <= '0;
                r_lo_cnt   <= '0;
                r_stb      <= 1'b0;
                r_sub      <= 1'b0;
            end else begin
                r_stb <= 1'b0;
                r_sub <= 1'b0;
                if (r_hi_cnt != '0) r_hi_cnt <= r_hi_cnt - 1'b1;
                if (r_lo_cnt != '0) r_lo_cnt <= r_lo_cnt - 1'b1;
                if (in_valid[g]) begin
                    r_stg0 <= w_d ? SYM_MARK : SYM_SPACE;
                    r_stg1 <= r_stg0;
                    r_stg2 <= r_stg1;
                    r_stg3 <= r_stg2;
                    if (w_sub) begin
                        r_stg0 <= SYM_V;
                        if (!w_v_odd_next) r_stg3 <= SYM_B;
                    end
                    r_zcnt     <= w_sub ? 3'd0 : w_zcnt_next;
                    r_last_pol <= w_last_pol_next;
                    r_v_odd    <= w_v_odd_next;
                    r_stb      <= 1'b1;
                    r_sub      <= w_sub;
                    if (w_pos) begin
                        r_hi_cnt <= ctrl_pw;
                        r_lo_cnt <= '0;
                    end else if (w_neg) begin
                        r_lo_cnt <= ctrl_pw;
                        r_hi_cnt <= '0;
                    end
                end
            end
        end

        assign w_hi_act    = (r_hi_cnt != '0);
        assign w_lo_act    = (r_lo_cnt != '0);
        assign out_hi[g]   = ctrl_invert[g] ? w_lo_act : w_hi_act;
        assign out_lo[g]   = ctrl_invert[g] ? w_hi_act : w_lo_act;
        assign out_stb[g]  = r_stb;
        assign stat_sub[g] = r_sub;
    end

endmodule

// File: tb/tb_e1_tx_line_enc.sv
// Directed bench for e1_tx_line_enc: HDB3/AMI symbol sequences, AIS, pulse
// widths, inversion and asynchronous reset, against hand-derived expectations.
module tb_e1_tx_line_enc;

    localparam int NL   = 2;
    localparam int PW_W = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NL-1:0]   in_bit = '0;
    logic [NL-1:0]   in_valid = '0;
    logic [NL-1:0]   ctrl_hdb3 = '0;
    logic [NL-1:0]   ctrl_ais = '0;
    logic [NL-1:0]   ctrl_invert = '0;
    logic [PW_W-1:0] ctrl_pw = '0;
    logic [NL-1:0]   out_hi, out_lo, out_stb, stat_sub;

    int n_checks = 0;
    int n_fail   = 0;

    logic [NL-1:0] s_stb, s_hi, s_lo, s_sub;
    int w_hi0, w_lo0, ov_cnt;

    e1_tx_line_enc #(.NL(NL), .PW_W(PW_W)) dut (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid),
        .ctrl_hdb3(ctrl_hdb3), .ctrl_ais(ctrl_ais), .ctrl_invert(ctrl_invert),
        .ctrl_pw(ctrl_pw), .out_hi(out_hi), .out_lo(out_lo),
        .out_stb(out_stb), .stat_sub(stat_sub)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One-cycle strobe; outputs are sampled 1 time unit after the strobe edge.
    task automatic strobe(input logic [NL-1:0] bits, input logic [NL-1:0] mask);
        @(negedge clk);
        in_bit   = bits;
        in_valid = mask;
        @(posedge clk);
        #1;
        in_valid = '0;
        s_stb = out_stb;
        s_hi  = out_hi;
        s_lo  = out_lo;
        s_sub = stat_sub;
        w_hi0 = out_hi[0] ? 1 : 0;
        w_lo0 = out_lo[0] ? 1 : 0;
        if ((out_hi & out_lo) != '0) ov_cnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (out_hi[0]) w_hi0++;
            if (out_lo[0]) w_lo0++;
            if ((out_hi & out_lo) != '0) ov_cnt++;
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (out_hi !== '0) begin n_fail++; $display("FAIL reset_out_hi got %b want 00", out_hi); end
        n_checks++;
        if (out_lo !== '0) begin n_fail++; $display("FAIL reset_out_lo got %b want 00", out_lo); end
        n_checks++;
        if (out_stb !== '0) begin n_fail++; $display("FAIL reset_out_stb got %b want 00", out_stb); end
        n_checks++;
        if (stat_sub !== '0) begin n_fail++; $display("FAIL reset_stat_sub got %b want 00", stat_sub); end
    endtask

    // Assumes the DUT was just reset.
    task automatic test_hdb3_zeros();
        string e = "0000+00+-00-";
        string s = "000100010001";
        logic [3:0] got, exp;
        ctrl_hdb3 = 2'b01; ctrl_ais = 2'b00; ctrl_invert = 2'b00; ctrl_pw = 5'd25;
        for (int k = 0; k < 12; k++) begin
            strobe(2'b00, 2'b01);
            got = {s_stb[0], s_hi[0], s_lo[0], s_sub[0]};
            exp = {1'b1, e[k] == "+", e[k] == "-", s[k] == "1"};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL hdb3_zeros[%0d] stb/hi/lo/sub got %b want %b", k, got, exp);
            end
            got = {s_stb[1], s_hi[1], s_lo[1], s_sub[1]};
            n_checks++;
            if (got !== 4'b0000) begin
                n_fail++;
                $display("FAIL hdb3_zeros_idle_line1[%0d] got %b want 0000", k, got);
            end
            idle(29);
            if (e[k] != "0") begin
                n_checks++;
                if (w_hi0 != (e[k] == "+" ? 25 : 0) || w_lo0 != (e[k] == "-" ? 25 : 0)) begin
                    n_fail++;
                    $display("FAIL hdb3_zeros_width[%0d] hi=%0d lo=%0d want %s for 25", k, w_hi0, w_lo0, (e[k] == "+") ? "hi" : "lo");
                end
            end
        end
    endtask

    task automatic test_hdb3_v_parity();
        string b = "1000000000000";
        string e = "0000+000+-00-";
        string s = "0000100010001";
        logic [3:0] got, exp;
        do_reset();
        ctrl_hdb3 = 2'b01; ctrl_ais = 2'b00; ctrl_pw = 5'd4;
        for (int k = 0; k < 13; k++) begin
            strobe((b[k] == "1") ? 2'b01 : 2'b00, 2'b01);
            got = {s_stb[0], s_hi[0], s_lo[0], s_sub[0]};
            exp = {1'b1, e[k] == "+", e[k] == "-", s[k] == "1"};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL hdb3_v_parity[%0d] stb/hi/lo/sub got %b want %b", k, got, exp);
            end
            idle(5);
        end
    endtask

    task automatic test_ami();
        string b = "11000010000";
        string e = "0000+-0000+";
        logic [3:0] got, exp;
        do_reset();
        ctrl_hdb3 = 2'b00; ctrl_ais = 2'b00; ctrl_pw = 5'd4;
        for (int k = 0; k < 11; k++) begin
            strobe((b[k] == "1") ? 2'b01 : 2'b00, 2'b01);
            got = {s_stb[0], s_hi[0], s_lo[0], s_sub[0]};
            exp = {1'b1, e[k] == "+", e[k] == "-", 1'b0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL ami[%0d] stb/hi/lo/sub got %b want %b", k, got, exp);
            end
            idle(5);
        end
    endtask

    task automatic test_ais_two_lines();
        string e0 = "0000+00+-00-";
        string s0 = "000100010001";
        string e1 = "0000+-+-+-+-";
        logic [3:0] got, exp;
        do_reset();
        ctrl_hdb3 = 2'b11; ctrl_ais = 2'b10; ctrl_pw = 5'd4;
        for (int k = 0; k < 12; k++) begin
            strobe(2'b00, 2'b11);
            got = {s_stb[0], s_hi[0], s_lo[0], s_sub[0]};
            exp = {1'b1, e0[k] == "+", e0[k] == "-", s0[k] == "1"};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL ais_line0[%0d] stb/hi/lo/sub got %b want %b", k, got, exp);
            end
            got = {s_stb[1], s_hi[1], s_lo[1], s_sub[1]};
            exp = {1'b1, e1[k] == "+", e1[k] == "-", 1'b0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL ais_line1[%0d] stb/hi/lo/sub got %b want %b", k, got, exp);
            end
            idle(5);
        end
        ctrl_ais = 2'b00;
    endtask

    task automatic test_pulse_boundary();
        logic [1:0] got, exp;
        do_reset();
        ctrl_hdb3 = 2'b00; ctrl_ais = 2'b01; ctrl_pw = 5'd3;
        ov_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            strobe(2'b00, 2'b01);
            exp = (k < 4) ? 2'b00 : ((k % 2 == 0) ? 2'b10 : 2'b01);
            got = {s_hi[0], s_lo[0]};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL pw3_polarity[%0d] hi/lo got %b want %b", k, got, exp);
            end
            idle(1);
            if (k >= 4) begin
                n_checks++;
                if ((w_hi0 + w_lo0) != 2 || (exp == 2'b10 && w_hi0 != 2)) begin
                    n_fail++;
                    $display("FAIL pw3_width[%0d] hi=%0d lo=%0d want 2 cycles", k, w_hi0, w_lo0);
                end
            end
        end
        n_checks++;
        if (ov_cnt != 0) begin n_fail++; $display("FAIL pw3_overlap got %0d want 0", ov_cnt); end
        ctrl_pw = 5'd0;
        for (int k = 0; k < 4; k++) begin
            strobe(2'b00, 2'b01);
            got = {s_hi[0], s_lo[0]};
            n_checks++;
            if (s_stb[0] !== 1'b1 || got !== 2'b00) begin
                n_fail++;
                $display("FAIL pw0[%0d] stb=%b hi/lo=%b want stb=1 hi/lo=00", k, s_stb[0], got);
            end
            idle(3);
            n_checks++;
            if (w_hi0 != 0 || w_lo0 != 0) begin
                n_fail++;
                $display("FAIL pw0_width[%0d] hi=%0d lo=%0d want 0", k, w_hi0, w_lo0);
            end
        end
        ctrl_ais = 2'b00;
    endtask

    task automatic test_invert();
        string b = "10000";
        string e = "0000+";
        logic [2:0] got, exp;
        do_reset();
        ctrl_hdb3 = 2'b00; ctrl_ais = 2'b00; ctrl_invert = 2'b01; ctrl_pw = 5'd4;
        for (int k = 0; k < 5; k++) begin
            strobe((b[k] == "1") ? 2'b01 : 2'b00, 2'b01);
            got = {s_stb[0], s_hi[0], s_lo[0]};
            exp = {1'b1, 1'b0, e[k] == "+"};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL invert[%0d] stb/hi/lo got %b want %b", k, got, exp);
            end
            idle(5);
        end
        ctrl_invert = 2'b00;
    endtask

    task automatic test_reset_mid_pulse();
        ctrl_hdb3 = 2'b01; ctrl_ais = 2'b00; ctrl_invert = 2'b00; ctrl_pw = 5'd25;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            strobe(2'b00, 2'b01);
            if (k < 4) idle(3);
        end
        idle(3);
        n_checks++;
        if (out_hi[0] !== 1'b1) begin n_fail++; $display("FAIL midpulse_pre hi got %b want 1", out_hi[0]); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out_hi, out_lo} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midpulse_rst hi/lo got %b want 0000", {out_hi, out_lo});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_hdb3_zeros();
    endtask

    initial begin
        do_reset();
        test_reset();
        test_hdb3_zeros();
        test_hdb3_v_parity();
        test_ami();
        test_ais_two_lines();
        test_pulse_boundary();
        test_invert();
        test_reset_mid_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/e1_tx_line_enc.md
Name: e1_tx_line_enc

Overview:
- Multi-line E1 TX low-level back end: NL independent lines, each taking bit/strobe pairs from a framer.
- Each line applies a per-line selectable line code (HDB3 or AMI) with optional AIS forcing.
- Each line generates hi/lo pulses of programmable width in clk cycles.
- Sits between the TX framer(s) and the TX PHY pad drivers. Replaces the fixed single-line encoder plus fixed-width pulse generator.

Parameters:
- NL, 1, number of independent E1 lines.
- PW_W, 5, width of the pulse-width control field.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- in_bit  in  NL  data bit per line (1 = mark).
- in_valid  in  NL  per-line bit strobe, single-cycle. Nominal spacing 2.048 MHz; minimum spacing 2 clk.
- ctrl_hdb3  in  NL  per line: 1 = HDB3, 0 = AMI.
- ctrl_ais  in  NL  per line: 1 = replace input data with all-ones.
- ctrl_invert  in  NL  per line: swap out_hi/out_lo.
- ctrl_pw  in  PW_W  pulse width in clk cycles, shared by all lines. 0 = output muted.
- out_hi  out  NL  positive pulse per line.
- out_lo  out  NL  negative pulse per line.
- out_stb  out  NL  one-cycle pulse when a symbol leaves the encoder.
- stat_sub  out  NL  one-cycle pulse when an HDB3 substitution is made.

Behaviour:
- Reset values: all outputs 0. Per line: 4-stage symbol pipeline = spaces; zero-run counter = 0; last_pol = negative (so the first mark is positive); v_parity = even; pulse counters = 0.
- Per-line data path, all actions occur on the cycle where in_valid[i] = 1:
  - Effective bit d = ctrl_ais ? 1 : in_bit.
  - Shift d into stage0. The stage3 symbol is popped for polarity assignment.
- Zero-run counter:
  - Increments on d = 0 (saturating at 4); clears on d = 1.
  - Clears whenever ctrl_hdb3 = 0.
- HDB3 substitution, when ctrl_hdb3 = 1 and the counter reaches 4 (d plus stages 1..3 all zeros):
  - v_parity even -> mark stage3 as B, stage0 as V (B00V).
  - v_parity odd -> mark stage0 as V (000V).
  - Counter clears; stat_sub pulses the next cycle.
- Polarity assignment of the popped symbol:
  - Mark or B: polarity = ~last_pol; last_pol updates; v_parity toggles.
  - V: polarity = last_pol; v_parity resets to even.
  - Space: no pulse.
- Latency: the bit accepted on strobe k is emitted on strobe k+4. out_stb and pulse start occur 1 clk after that strobe. The first 4 strobes after reset emit spaces.
- Pulse generator, per line, separate hi and lo counters:
  - On symbol emit with a positive pulse: hi counter loads ctrl_pw and lo counter clears. Mirror for negative.
  - Otherwise each counter decrements while nonzero.
  - out_hi = (hi_cnt != 0), out_lo = (lo_cnt != 0), swapped when ctrl_invert = 1.
  - Pulse width is exactly ctrl_pw cycles.
  - A strobe arriving before the previous pulse ends reloads or truncates; out_hi and out_lo are never both 1.
  - ctrl_pw = 0 -> no pulses, but the encoder state still advances.
- Control changes:
  - ctrl_hdb3 / ctrl_ais changes take effect on the next strobe; the pipeline is not flushed.
  - ctrl_pw change affects the next load only.
- rst asserted mid-pulse or mid-substitution: immediate return to reset state; outputs low in the same cycle.
- Lines are fully independent; simultaneous strobes on all lines are legal.

Test Plan:
- HDB3, all zeros from reset, pw = 25:
  - Strobes 1-4 -> spaces.
  - Then symbols +,0,0,+ | -,0,0,- | +,0,0,+ …
  - Each pulse is exactly 25 clk high; stat_sub fires every 4th strobe.
- HDB3, input 1,0,0,0,0 from reset:
  - Emitted +,0,0,0,+ (000V: odd parity, V same polarity as the preceding mark).
  - Next 0000 -> -,0,0,- (B00V).
- AMI, input 1,1,0,0,0,0,1 -> +,-,0,0,0,0,+; stat_sub never asserts.
- ctrl_ais = 1 on line 1 while line 0 runs HDB3 zeros (NL = 2):
  - Line 1 emits strictly alternating marks.
  - Line 0 sequence is unaffected.
- Pulse boundaries:
  - pw = 3, strobes every 2 clk, alternating marks -> hi is high 2 clk, then lo loads; never overlap.
  - pw = 0 -> outputs stay 0 while out_stb still pulses.
  - ctrl_invert = 1 -> first mark appears on out_lo.
- Assert rst mid-pulse -> outputs 0 immediately. After release, the sequence restarts exactly as in the first scenario.
